// File: rtl/regfile_arb_pkg.sv
// ---------------------------------------------------------------------------
// regfile_arb_pkg
// Shared definitions for the register-file write-port arbiter.
//   - arb_state_t : arbiter ownership state (idle, owned by req0, owned by req1)
//   - DEF_*       : default widths and burst limit used by the top level
//   - REQ0 / REQ1 : requester index constants (0 = ALU writeback, 1 = load)
// ---------------------------------------------------------------------------
package regfile_arb_pkg;

   localparam int DEF_DATA_W    = 8;
   localparam int DEF_ADDR_W    = 3;
   localparam int DEF_BURST_MAX = 4;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_OWN0 = 2'd1,
      ARB_OWN1 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin picker with an owner override.
// Ports:
//   i_valid      [1:0] request present per requester
//   i_last_grant       index of the requester granted most recently
//   i_own_en           a locked owner currently holds the port
//   i_own_idx          index of that owner
//   o_grant      [1:0] one-hot grant (all zero when nothing is valid)
// ---------------------------------------------------------------------------
module rr_arb2
   import regfile_arb_pkg::*;
(
   input  logic [1:0] i_valid,
   input  logic       i_last_grant,
   input  logic       i_own_en,
   input  logic       i_own_idx,
   output logic [1:0] o_grant
);

   // An owner that is still requesting wins outright. An owner that has
   // dropped valid is ignored, so the choice falls back to plain
   // round-robin: with both valid, the one not granted last time wins.
   always_comb begin
      o_grant = 2'b00;
      if (i_own_en && i_valid[i_own_idx]) begin
         o_grant = (i_own_idx == REQ1) ? 2'b10 : 2'b01;
      end else if (i_valid == 2'b11) begin
         o_grant = (i_last_grant == REQ1) ? 2'b01 : 2'b10;
      end else begin
         o_grant = i_valid;
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
// Shares the register file's single write port between requester 0 (ALU
// writeback) and requester 1 (load writeback). Round-robin fairness with an
// optional lock that keeps the port for up to BURST_MAX consecutive grants.
// The accepted write is registered and presented as a one-cycle RegWrite
// pulse with Write_Reg_Num / Write_Data on the cycle after the handshake.
// Ports:
//   clk, Reset (async, active high)
//   reqN_valid / reqN_lock / reqN_addr / reqN_data   requester inputs
//   reqN_ready                                       combinational grant
//   RegWrite / Write_Reg_Num / Write_Data            register file write
// Build option:
//   REGFILE_ARB_ZERO_REG_EN - writes to register 0 are accepted and
//   arbitrated but never strobe RegWrite.
// ---------------------------------------------------------------------------
module regfile_write_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int BURST_MAX = DEF_BURST_MAX
)(
   input  logic              clk,
   input  logic              Reset,
   input  logic              req0_valid,
   input  logic              req0_lock,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   input  logic              req1_valid,
   input  logic              req1_lock,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req0_ready,
   output logic              req1_ready,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] Write_Reg_Num,
   output logic [DATA_W-1:0] Write_Data
);

   localparam int CNT_W = $clog2(BURST_MAX + 1);

   arb_state_t        r_state;
   logic              r_lastGrant;
   logic [CNT_W-1:0]  r_burstCnt;
   logic              r_regWrite;
   logic [ADDR_W-1:0] r_writeRegNum;
   logic [DATA_W-1:0] r_writeData;

   logic              w_ownEn;
   logic              w_ownIdx;
   logic [1:0]        w_grant;
   logic              w_hs;
   logic              w_hsIdx;
   logic              w_hsLock;
   logic [ADDR_W-1:0] w_hsAddr;
   logic [DATA_W-1:0] w_hsData;
   logic [CNT_W-1:0]  w_baseCnt;
   logic [CNT_W-1:0]  w_nextCnt;
   logic              w_keep;
   logic              w_doWrite;

   assign w_ownEn  = (r_state != ARB_IDLE);
   assign w_ownIdx = (r_state == ARB_OWN1);

   rr_arb2 u_pick (
      .i_valid      ({req1_valid, req0_valid}),
      .i_last_grant (r_lastGrant),
      .i_own_en     (w_ownEn),
      .i_own_idx    (w_ownIdx),
      .o_grant      (w_grant)
   );

   // Ready is suppressed while Reset is held so nothing handshakes into
   // flops that cannot capture it.
   assign req0_ready = w_grant[0] & ~Reset;
   assign req1_ready = w_grant[1] & ~Reset;

   assign w_hs     = |w_grant;
   assign w_hsIdx  = w_grant[1];
   assign w_hsLock = w_hsIdx ? req1_lock : req0_lock;
   assign w_hsAddr = w_hsIdx ? req1_addr : req0_addr;
   assign w_hsData = w_hsIdx ? req1_data : req0_data;

   // The burst continues only when the current owner is the one granted;
   // a grant to anyone else (owner dropped valid, or idle) starts at 1.
   assign w_baseCnt = (w_ownEn && (w_ownIdx == w_hsIdx)) ? r_burstCnt : '0;
   assign w_nextCnt = w_baseCnt + CNT_W'(1);
   assign w_keep    = w_hsLock && (w_nextCnt < CNT_W'(BURST_MAX));

`ifdef REGFILE_ARB_ZERO_REG_EN
   assign w_doWrite = w_hs && (w_hsAddr != '0);
`else
   assign w_doWrite = w_hs;
`endif

   // Ownership FSM, round-robin history, burst counter and the registered
   // write port. The write address/data hold when no write is emitted.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         r_state       <= ARB_IDLE;
         r_lastGrant   <= REQ1;
         r_burstCnt    <= '0;
         r_regWrite    <= 1'b0;
         r_writeRegNum <= '0;
         r_writeData   <= '0;
      end else begin
         r_regWrite <= w_doWrite;
         if (w_doWrite) begin
            r_writeRegNum <= w_hsAddr;
            r_writeData   <= w_hsData;
         end
         if (w_hs) begin
            r_lastGrant <= w_hsIdx;
            if (w_keep) begin
               r_state    <= w_hsIdx ? ARB_OWN1 : ARB_OWN0;
               r_burstCnt <= w_nextCnt;
            end else begin
               r_state    <= ARB_IDLE;
               r_burstCnt <= '0;
            end
         end else begin
            r_state    <= ARB_IDLE;
            r_burstCnt <= '0;
         end
      end
   end

   assign RegWrite      = r_regWrite;
   assign Write_Reg_Num = r_writeRegNum;
   assign Write_Data    = r_writeData;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
// Directed vectors for the register-file write arbiter: a table of
// per-cycle requests with hand-computed readies and next-cycle write port
// values, followed by a hand-written reset-during-burst sequence.
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;

   logic       clk = 1'b0;
   logic       Reset;
   logic       req0_valid, req0_lock, req1_valid, req1_lock;
   logic [2:0] req0_addr, req1_addr;
   logic [7:0] req0_data, req1_data;
   logic       req0_ready, req1_ready;
   logic       RegWrite;
   logic [2:0] Write_Reg_Num;
   logic [7:0] Write_Data;

   int nChecks = 0;
   int nPass   = 0;

   typedef struct {
      logic       v0;
      logic       l0;
      logic [2:0] a0;
      logic [7:0] d0;
      logic       v1;
      logic       l1;
      logic [2:0] a1;
      logic [7:0] d1;
      logic       er0;
      logic       er1;
      logic       erw;
      logic [2:0] ena;
      logic [7:0] edat;
   } vec_t;

   vec_t vecs[$];

   regfile_write_arbiter dut (
      .clk           (clk),
      .Reset         (Reset),
      .req0_valid    (req0_valid),
      .req0_lock     (req0_lock),
      .req0_addr     (req0_addr),
      .req0_data     (req0_data),
      .req1_valid    (req1_valid),
      .req1_lock     (req1_lock),
      .req1_addr     (req1_addr),
      .req1_data     (req1_data),
      .req0_ready    (req0_ready),
      .req1_ready    (req1_ready),
      .RegWrite      (RegWrite),
      .Write_Reg_Num (Write_Reg_Num),
      .Write_Data    (Write_Data)
   );

   // Free-running 10-unit clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic v0, input logic l0, input logic [2:0] a0,
                               input logic [7:0] d0, input logic v1, input logic l1,
                               input logic [2:0] a1, input logic [7:0] d1,
                               input logic er0, input logic er1, input logic erw,
                               input logic [2:0] ena, input logic [7:0] edat);
      vec_t v;
      v.v0 = v0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
      v.v1 = v1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
      v.er0 = er0; v.er1 = er1; v.erw = erw; v.ena = ena; v.edat = edat;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      nChecks++;
      if (actual === expected) begin
         nPass++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      req0_valid = v.v0; req0_lock = v.l0; req0_addr = v.a0; req0_data = v.d0;
      req1_valid = v.v1; req1_lock = v.l1; req1_addr = v.a1; req1_data = v.d1;
   endtask

   // Drive one vector just after a rising edge, check readies mid-cycle,
   // then check the registered write port just after the next rising edge.
   task automatic runVector(input int idx, input vec_t v);
      string tag;
      tag = $sformatf("vec%0d", idx);
      applyStimulus(v);
      #1;
      checkOutput({tag, " req0_ready"}, 32'(req0_ready), 32'(v.er0));
      checkOutput({tag, " req1_ready"}, 32'(req1_ready), 32'(v.er1));
      @(posedge clk);
      #1;
      checkOutput({tag, " RegWrite"},      32'(RegWrite),      32'(v.erw));
      checkOutput({tag, " Write_Reg_Num"}, 32'(Write_Reg_Num), 32'(v.ena));
      checkOutput({tag, " Write_Data"},    32'(Write_Data),    32'(v.edat));
   endtask

   initial begin
      // Table layout: req0 {valid,lock,addr,data}, req1 {valid,lock,addr,data},
      // expected {ready0, ready1}, expected next cycle {RegWrite, num, data}.
      // Alternation straight out of reset: req0 first (last_grant resets to 1).
      vecs.push_back(mk(1'b1,1'b0,3'd1,8'h11, 1'b1,1'b0,3'd2,8'h22, 1'b1,1'b0, 1'b1,3'd1,8'h11));
      vecs.push_back(mk(1'b1,1'b0,3'd3,8'h33, 1'b1,1'b0,3'd2,8'h22, 1'b0,1'b1, 1'b1,3'd2,8'h22));
      vecs.push_back(mk(1'b1,1'b0,3'd3,8'h33, 1'b1,1'b0,3'd4,8'h44, 1'b1,1'b0, 1'b1,3'd3,8'h33));
      vecs.push_back(mk(1'b1,1'b0,3'd5,8'h55, 1'b1,1'b0,3'd4,8'h44, 1'b0,1'b1, 1'b1,3'd4,8'h44));
      vecs.push_back(mk(1'b0,1'b0,3'd0,8'h00, 1'b0,1'b0,3'd0,8'h00, 1'b0,1'b0, 1'b0,3'd4,8'h44));
      // Single request, then a one-cycle pulse that drops and holds.
      vecs.push_back(mk(1'b1,1'b0,3'd5,8'h3C, 1'b0,1'b0,3'd0,8'h00, 1'b1,1'b0, 1'b1,3'd5,8'h3C));
      vecs.push_back(mk(1'b0,1'b0,3'd0,8'h00, 1'b0,1'b0,3'd0,8'h00, 1'b0,1'b0, 1'b0,3'd5,8'h3C));
      // req1 locked burst: 4 grants, forced release to req0, then req1 again.
      vecs.push_back(mk(1'b0,1'b0,3'd0,8'h00, 1'b1,1'b1,3'd6,8'h61, 1'b0,1'b1, 1'b1,3'd6,8'h61));
      vecs.push_back(mk(1'b1,1'b0,3'd7,8'h70, 1'b1,1'b1,3'd6,8'h62, 1'b0,1'b1, 1'b1,3'd6,8'h62));
      vecs.push_back(mk(1'b1,1'b0,3'd7,8'h70, 1'b1,1'b1,3'd6,8'h63, 1'b0,1'b1, 1'b1,3'd6,8'h63));
      vecs.push_back(mk(1'b1,1'b0,3'd7,8'h70, 1'b1,1'b1,3'd6,8'h64, 1'b0,1'b1, 1'b1,3'd6,8'h64));
      vecs.push_back(mk(1'b1,1'b0,3'd7,8'h70, 1'b1,1'b1,3'd6,8'h65, 1'b1,1'b0, 1'b1,3'd7,8'h70));
      vecs.push_back(mk(1'b1,1'b0,3'd1,8'h71, 1'b1,1'b1,3'd6,8'h65, 1'b0,1'b1, 1'b1,3'd6,8'h65));
      vecs.push_back(mk(1'b0,1'b0,3'd0,8'h00, 1'b0,1'b0,3'd0,8'h00, 1'b0,1'b0, 1'b0,3'd6,8'h65));
      // req0 locked owner drops valid: req1 takes the port, then idle arbitration.
      vecs.push_back(mk(1'b1,1'b1,3'd2,8'hA1, 1'b0,1'b0,3'd0,8'h00, 1'b1,1'b0, 1'b1,3'd2,8'hA1));
      vecs.push_back(mk(1'b0,1'b1,3'd2,8'hA1, 1'b1,1'b0,3'd3,8'hB1, 1'b0,1'b1, 1'b1,3'd3,8'hB1));
      vecs.push_back(mk(1'b1,1'b0,3'd2,8'hA2, 1'b1,1'b0,3'd3,8'hB2, 1'b1,1'b0, 1'b1,3'd2,8'hA2));
      // Write to register 0.
`ifdef REGFILE_ARB_ZERO_REG_EN
      vecs.push_back(mk(1'b1,1'b0,3'd0,8'hFF, 1'b0,1'b0,3'd0,8'h00, 1'b1,1'b0, 1'b0,3'd2,8'hA2));
      vecs.push_back(mk(1'b0,1'b0,3'd0,8'h00, 1'b0,1'b0,3'd0,8'h00, 1'b0,1'b0, 1'b0,3'd2,8'hA2));
`else
      vecs.push_back(mk(1'b1,1'b0,3'd0,8'hFF, 1'b0,1'b0,3'd0,8'h00, 1'b1,1'b0, 1'b1,3'd0,8'hFF));
      vecs.push_back(mk(1'b0,1'b0,3'd0,8'h00, 1'b0,1'b0,3'd0,8'h00, 1'b0,1'b0, 1'b0,3'd0,8'hFF));
`endif

      // Reset with both requesters asking: readies must stay low.
      Reset = 1'b1;
      applyStimulus(mk(1'b1,1'b0,3'd1,8'h11, 1'b1,1'b0,3'd2,8'h22, 1'b0,1'b0, 1'b0,3'd0,8'h00));
      #2;
      checkOutput("reset req0_ready",    32'(req0_ready),    32'd0);
      checkOutput("reset req1_ready",    32'(req1_ready),    32'd0);
      checkOutput("reset RegWrite",      32'(RegWrite),      32'd0);
      checkOutput("reset Write_Reg_Num", 32'(Write_Reg_Num), 32'd0);
      checkOutput("reset Write_Data",    32'(Write_Data),    32'd0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #10;
      Reset = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         runVector(i, vecs[i]);
      end

      // Reset asserted during the 2nd grant of a req1 locked burst.
      applyStimulus(mk(1'b0,1'b0,3'd0,8'h00, 1'b1,1'b1,3'd4,8'h5A, 1'b0,1'b0, 1'b0,3'd0,8'h00));
      #1;
      checkOutput("burst1 req1_ready", 32'(req1_ready), 32'd1);
      @(posedge clk);
      #1;
      checkOutput("burst1 RegWrite", 32'(RegWrite),   32'd1);
      checkOutput("burst1 data",     32'(Write_Data), 32'h5A);
      applyStimulus(mk(1'b1,1'b0,3'd1,8'h11, 1'b1,1'b1,3'd4,8'h5B, 1'b0,1'b0, 1'b0,3'd0,8'h00));
      #1;
      checkOutput("burst2 req0_ready", 32'(req0_ready), 32'd0);
      checkOutput("burst2 req1_ready", 32'(req1_ready), 32'd1);
      @(posedge clk);
      #1;
      checkOutput("burst2 RegWrite", 32'(RegWrite),   32'd1);
      checkOutput("burst2 data",     32'(Write_Data), 32'h5B);
      #1;
      Reset = 1'b1;
      #1;
      checkOutput("midreset RegWrite",      32'(RegWrite),      32'd0);
      checkOutput("midreset Write_Reg_Num", 32'(Write_Reg_Num), 32'd0);
      checkOutput("midreset req1_ready",    32'(req1_ready),    32'd0);
      @(negedge clk);
      Reset = 1'b0;
      #1;
      checkOutput("postreset req0_ready", 32'(req0_ready), 32'd1);
      checkOutput("postreset req1_ready", 32'(req1_ready), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("postreset RegWrite",      32'(RegWrite),      32'd1);
      checkOutput("postreset Write_Reg_Num", 32'(Write_Reg_Num), 32'd1);
      checkOutput("postreset Write_Data",    32'(Write_Data),    32'h11);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("final RegWrite", 32'(RegWrite), 32'd0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between two writeback requesters (requester 0: ALU writeback, requester 1: load writeback). Valid/ready handshake per requester, round-robin fairness, optional bounded burst lock. The accepted write is registered and driven onto the register file's RegWrite / Write_Reg_Num / Write_Data inputs one cycle later as a one-cycle pulse.

## Interface
- DATA_W, 8, write data width (matches register file entries)
- ADDR_W, 3, register number width (8 registers)
- BURST_MAX, 4, maximum consecutive locked grants to one requester (≥1)

- clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  write request present
- req0_lock / req1_lock  in  1  requester wants to keep the port after this grant
- req0_addr / req1_addr  in  ADDR_W  destination register
- req0_data / req1_data  in  DATA_W  write data
- req0_ready / req1_ready  out  1  grant; handshake = valid & ready at rising edge
- RegWrite  out  1  registered write strobe to register file
- Write_Reg_Num  out  ADDR_W  registered destination
- Write_Data  out  DATA_W  registered data

## Operation
- State: ARB_IDLE, ARB_OWN0, ARB_OWN1; plus last_grant (1 bit) and burst_cnt (width for 0..BURST_MAX).
- At most one ready high per cycle; ready never high without matching valid.
- ARB_IDLE: one valid → that requester granted. Both valid → requester != last_grant granted.
- ARB_OWNn: reqn_valid=1 → requester n granted regardless of the other. reqn_valid=0 → ownership dropped this cycle (state treated as ARB_IDLE for arbitration, next state ARB_IDLE).
- On handshake by requester n: last_grant←n; burst_cnt←burst_cnt+1 (from 0 if entering from idle).
  - reqn_lock=1 and new burst_cnt < BURST_MAX → ARB_OWNn.
  - else → ARB_IDLE, burst_cnt←0.
- No handshake → ARB_IDLE, burst_cnt←0.
- Forced release at BURST_MAX gives the other requester priority next cycle via last_grant; if the other is idle, the same requester may be granted again and starts a new burst.
- Output stage: on handshake, Write_Reg_Num/Write_Data ← granted addr/data, RegWrite←1; otherwise RegWrite←0, Write_Reg_Num/Write_Data hold.

## Timing
- Handshake at edge N → RegWrite high for exactly cycle N..N+1 with that address/data; throughput one write per cycle.
- ready is combinational from valid, lock state, last_grant; forced 0 while Reset high.
- Reset values: RegWrite=0, Write_Reg_Num=0, Write_Data=0, state=ARB_IDLE, burst_cnt=0, last_grant=1 (requester 0 has first priority).
- Reset asserted mid-burst: burst abandoned immediately, in-flight RegWrite pulse cleared asynchronously; no write emitted.
- Requester must hold valid/addr/data/lock stable until handshake.

## Configuration
- REGFILE_ARB_ZERO_REG_EN defined: requests with addr 0 are handshaked and arbitrated normally (update last_grant/burst_cnt) but RegWrite stays 0 the following cycle; Write_Reg_Num/Write_Data hold. Register 0 is never written.
- Undefined: addr 0 is written like any other register.

## Structure
- Package regfile_arb_pkg: state typedef (ARB_IDLE, ARB_OWN0, ARB_OWN1), default DATA_W/ADDR_W/BURST_MAX constants, requester index constants.
- Sub-module rr_arb2: combinational 2-way picker (valids, last_grant, owner override → one-hot grant). Top holds FSM, counter, output register.

## Test plan
- Reset then req0 only, addr=5 data=0x3C, lock=0 → req0_ready same cycle; next cycle RegWrite=1, Write_Reg_Num=5, Write_Data=0x3C; cycle after RegWrite=0.
- Both valid continuously, lock=0, from reset → grants alternate 0,1,0,1; RegWrite high every cycle with matching addr/data.
- Both valid, req1 lock=1, BURST_MAX=4, req1 granted first → req1 granted 4 consecutive cycles, then req0 granted, then req1.
- req0 locked owner drops valid one cycle while req1 valid → req1 granted that cycle; state ARB_IDLE afterward.
- Reset pulsed during 2nd grant of a locked burst → RegWrite=0 immediately, after release req0 has priority over req1.
- REGFILE_ARB_ZERO_REG_EN defined, req0 addr=0 data=0xFF → req0_ready=1, RegWrite stays 0; undefined → RegWrite=1, Write_Reg_Num=0, Write_Data=0xFF.
